// File: rtl/edge_threshold_stats_if.sv
// rtl/edge_threshold_stats_if.sv - pixel stream in/out and per-frame statistics bundle
interface edge_threshold_stats_if;
    logic        in_valid;
    logic [7:0]  in_pixel;
    logic [7:0]  thr;
    logic        out_valid;
    logic [7:0]  out_pixel;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        frame_done;
    logic [31:0] edge_count;
    logic [7:0]  peak_mag;
    logic        bbox_valid;
    logic [15:0] bbox_xmin;
    logic [15:0] bbox_xmax;
    logic [15:0] bbox_ymin;
    logic [15:0] bbox_ymax;

    modport slave (
        input  in_valid, in_pixel, thr,
        output out_valid, out_pixel, out_sof, out_eol, out_eof, frame_done,
        output edge_count, peak_mag, bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );

    modport master (
        output in_valid, in_pixel, thr,
        input  out_valid, out_pixel, out_sof, out_eol, out_eof, frame_done,
        input  edge_count, peak_mag, bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );
endinterface

// File: rtl/edge_threshold_stats.sv
// rtl/edge_threshold_stats.sv - binarise edge magnitudes and publish per-frame edge statistics
module edge_threshold_stats #(
    parameter int W = 630,
    parameter int H = 630
) (
    input  logic                   clk,
    input  logic                   rst_n,
    edge_threshold_stats_if.slave  s
);
    localparam logic [15:0] XLAST = 16'(W - 1);
    localparam logic [15:0] YLAST = 16'(H - 1);

    logic [15:0] x, y;
    logic [7:0]  thr_eff;
    logic [31:0] cnt;
    logic [7:0]  pk;
    logic        any;
    logic [15:0] xmin, xmax, ymin, ymax;

    logic        first, eol, last, is_edge;
    logic [7:0]  thr_use;
    logic [31:0] base_cnt, cnt_n;
    logic [7:0]  base_pk, pk_n;
    logic        base_any, any_n;
    logic [15:0] xmin_n, xmax_n, ymin_n, ymax_n;

    assign first   = (x == 16'd0) && (y == 16'd0);
    assign eol     = (x == XLAST);
    assign last    = eol && (y == YLAST);
    // the first pixel of a frame sees the live threshold, not the stale latch
    assign thr_use = first ? s.thr : thr_eff;
    assign is_edge = (s.in_pixel >= thr_use);

    always_comb begin
        // pixel (0,0) restarts the accumulators instead of merging into them
        base_cnt = first ? 32'd0 : cnt;
        base_pk  = first ? 8'd0  : pk;
        base_any = first ? 1'b0  : any;
        cnt_n    = base_cnt + 32'(is_edge);
        pk_n     = (s.in_pixel > base_pk) ? s.in_pixel : base_pk;
        any_n    = base_any | is_edge;
        xmin_n   = xmin;
        xmax_n   = xmax;
        ymin_n   = ymin;
        ymax_n   = ymax;
        if (is_edge) begin
            if (!base_any) begin
                xmin_n = x;
                xmax_n = x;
                ymin_n = y;
                ymax_n = y;
            end else begin
                xmin_n = (x < xmin) ? x : xmin;
                xmax_n = (x > xmax) ? x : xmax;
                ymin_n = (y < ymin) ? y : ymin;
                ymax_n = (y > ymax) ? y : ymax;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= 16'd0;
            y       <= 16'd0;
            thr_eff <= 8'd0;
            cnt     <= 32'd0;
            pk      <= 8'd0;
            any     <= 1'b0;
            xmin    <= 16'd0;
            xmax    <= 16'd0;
            ymin    <= 16'd0;
            ymax    <= 16'd0;
        end else if (s.in_valid) begin
            if (first) thr_eff <= s.thr;
            if (eol) begin
                x <= 16'd0;
                y <= last ? 16'd0 : y + 16'd1;
            end else begin
                x <= x + 16'd1;
            end
            cnt  <= cnt_n;
            pk   <= pk_n;
            any  <= any_n;
            xmin <= xmin_n;
            xmax <= xmax_n;
            ymin <= ymin_n;
            ymax <= ymax_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_valid  <= 1'b0;
            s.out_pixel  <= 8'd0;
            s.out_sof    <= 1'b0;
            s.out_eol    <= 1'b0;
            s.out_eof    <= 1'b0;
            s.frame_done <= 1'b0;
            s.edge_count <= 32'd0;
            s.peak_mag   <= 8'd0;
            s.bbox_valid <= 1'b0;
            s.bbox_xmin  <= 16'd0;
            s.bbox_xmax  <= 16'd0;
            s.bbox_ymin  <= 16'd0;
            s.bbox_ymax  <= 16'd0;
        end else begin
            s.out_valid  <= s.in_valid;
            s.out_sof    <= s.in_valid && first;
            s.out_eol    <= s.in_valid && eol;
            s.out_eof    <= s.in_valid && last;
            s.frame_done <= s.in_valid && last;
            if (s.in_valid) s.out_pixel <= is_edge ? 8'd255 : 8'd0;
            if (s.in_valid && last) begin
                s.edge_count <= cnt_n;
                s.peak_mag   <= pk_n;
                s.bbox_valid <= any_n;
                s.bbox_xmin  <= any_n ? xmin_n : 16'd0;
                s.bbox_xmax  <= any_n ? xmax_n : 16'd0;
                s.bbox_ymin  <= any_n ? ymin_n : 16'd0;
                s.bbox_ymax  <= any_n ? ymax_n : 16'd0;
            end
        end
    end
endmodule

// File: tb/tb_edge_threshold_stats.sv
// tb/tb_edge_threshold_stats.sv - directed-vector bench for edge_threshold_stats on a 4x3 frame
module tb_edge_threshold_stats;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_threshold_stats_if bus();
    edge_threshold_stats #(.W(W), .H(H)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

    int vectors = 0;
    int miscompares = 0;
    int lat_err = 0;
    int fd_err = 0;
    logic prev_valid = 1'b0;
    logic [7:0]  q_pix[$];
    logic [2:0]  q_mk[$];
    logic [31:0] q_cnt[$];
    logic [7:0]  px[N];
    logic [7:0]  exp_pix[N];

    // one cycle: record what the DUT produced for the previous cycle, then apply new inputs
    task automatic drive(input logic v, input logic [7:0] p, input logic [7:0] t);
        @(negedge clk);
        if (bus.out_valid !== prev_valid) lat_err++;
        if (bus.frame_done !== (bus.out_valid && bus.out_eof)) fd_err++;
        if (bus.out_valid) begin
            q_pix.push_back(bus.out_pixel);
            q_mk.push_back({bus.out_sof, bus.out_eol, bus.out_eof});
        end
        if (bus.frame_done) q_cnt.push_back(bus.edge_count);
        bus.in_valid = v;
        bus.in_pixel = p;
        bus.thr      = t;
        prev_valid   = v;
    endtask

    task automatic send_frame(input logic [7:0] t0, input logic [7:0] t1, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'hAA, 8'hEE);
            drive(1'b1, px[i], (i < 6) ? t0 : t1);
        end
    endtask

    task automatic flush();
        repeat (2) drive(1'b0, 8'h00, 8'hEE);
    endtask

    task automatic clear_q();
        q_pix.delete();
        q_mk.delete();
        q_cnt.delete();
        lat_err = 0;
        fd_err  = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'd0;
        bus.thr      = 8'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, bus.frame_done, bus.bbox_valid} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset flags got %b exp 000000",
                     {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, bus.frame_done, bus.bbox_valid});
        end
        vectors++;
        if ({bus.out_pixel, bus.peak_mag, bus.edge_count} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset pix/peak/count got %h exp 0", {bus.out_pixel, bus.peak_mag, bus.edge_count});
        end
        vectors++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset bbox got %h exp 0", {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp(input bit gaps, input string tag);
        clear_q();
        for (int i = 0; i < N; i++) begin
            px[i]      = 8'(i * 10);
            exp_pix[i] = (i >= 10) ? 8'd255 : 8'd0;
        end
        send_frame(8'd100, 8'd100, gaps);
        flush();
        vectors++;
        if (q_pix.size() !== N) begin
            miscompares++;
            $display("FAIL %s out_count got %0d exp %0d", tag, q_pix.size(), N);
        end
        for (int i = 0; i < N && i < q_pix.size(); i++) begin
            vectors++;
            if ({q_pix[i], q_mk[i]} !== {exp_pix[i], (i == 0), ((i % W) == W - 1), (i == N - 1)}) begin
                miscompares++;
                $display("FAIL %s out[%0d] got pix=%0d mk=%b exp pix=%0d mk=%b", tag, i, q_pix[i], q_mk[i],
                         exp_pix[i], {(i == 0), ((i % W) == W - 1), (i == N - 1)});
            end
        end
        vectors++;
        if (lat_err !== 0 || fd_err !== 0) begin
            miscompares++;
            $display("FAIL %s latency/frame_done errors got %0d/%0d exp 0/0", tag, lat_err, fd_err);
        end
        vectors++;
        if ({bus.edge_count, bus.peak_mag, bus.bbox_valid} !== {32'd2, 8'd110, 1'b1}) begin
            miscompares++;
            $display("FAIL %s count/peak/valid got %0d/%0d/%b exp 2/110/1", tag, bus.edge_count, bus.peak_mag, bus.bbox_valid);
        end
        vectors++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !== {16'd2, 16'd3, 16'd2, 16'd2}) begin
            miscompares++;
            $display("FAIL %s bbox got %h exp 0002000300020002", tag,
                     {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax});
        end
    endtask

    task automatic test_zero_frame();
        clear_q();
        for (int i = 0; i < N; i++) px[i] = 8'd0;
        send_frame(8'd1, 8'd1, 1'b0);
        flush();
        vectors++;
        if (q_pix.size() !== N) begin
            miscompares++;
            $display("FAIL zero out_count got %0d exp %0d", q_pix.size(), N);
        end
        for (int i = 0; i < N && i < q_pix.size(); i++) begin
            vectors++;
            if (q_pix[i] !== 8'd0) begin
                miscompares++;
                $display("FAIL zero out[%0d] got %0d exp 0", i, q_pix[i]);
            end
        end
        vectors++;
        if ({bus.edge_count, bus.peak_mag, bus.bbox_valid} !== 41'd0) begin
            miscompares++;
            $display("FAIL zero count/peak/valid got %0d/%0d/%b exp 0/0/0", bus.edge_count, bus.peak_mag, bus.bbox_valid);
        end
        vectors++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !== 64'd0) begin
            miscompares++;
            $display("FAIL zero bbox got %h exp 0", {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax});
        end
        send_frame(8'd0, 8'd0, 1'b0);
        flush();
        vectors++;
        if ({bus.edge_count, bus.peak_mag, bus.bbox_valid} !== {32'd12, 8'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL thr0 count/peak/valid got %0d/%0d/%b exp 12/0/1", bus.edge_count, bus.peak_mag, bus.bbox_valid);
        end
        vectors++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !== {16'd0, 16'd3, 16'd0, 16'd2}) begin
            miscompares++;
            $display("FAIL thr0 bbox got %h exp 0000000300000002",
                     {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax});
        end
    endtask

    task automatic test_thr_change();
        clear_q();
        for (int i = 0; i < N; i++) px[i] = 8'd100;
        send_frame(8'd50, 8'd200, 1'b0);
        flush();
        vectors++;
        if ({bus.edge_count, bus.peak_mag} !== {32'd12, 8'd100}) begin
            miscompares++;
            $display("FAIL thrmid count/peak got %0d/%0d exp 12/100", bus.edge_count, bus.peak_mag);
        end
        clear_q();
        px[0] = 8'd210;
        send_frame(8'd200, 8'd200, 1'b0);
        flush();
        vectors++;
        if (q_pix.size() < 2 || q_pix[0] !== 8'd255 || q_pix[1] !== 8'd0) begin
            miscompares++;
            $display("FAIL thrnew first outputs got %0d/%0d exp 255/0", q_pix[0], q_pix[1]);
        end
        vectors++;
        if ({bus.edge_count, bus.peak_mag, bus.bbox_valid} !== {32'd1, 8'd210, 1'b1}) begin
            miscompares++;
            $display("FAIL thrnew count/peak/valid got %0d/%0d/%b exp 1/210/1", bus.edge_count, bus.peak_mag, bus.bbox_valid);
        end
        vectors++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !== 64'd0) begin
            miscompares++;
            $display("FAIL thrnew bbox got %h exp 0", {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax});
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int i = 0; i < N; i++) px[i] = 8'd200;
        send_frame(8'd10, 8'd10, 1'b0);
        for (int i = 0; i < N; i++) px[i] = (i == 5) ? 8'd90 : 8'd5;
        send_frame(8'd80, 8'd80, 1'b0);
        flush();
        vectors++;
        if (q_cnt.size() !== 2 || q_cnt[0] !== 32'd12 || q_cnt[1] !== 32'd1) begin
            miscompares++;
            $display("FAIL b2b frame_done counts got n=%0d %0d,%0d exp n=2 12,1", q_cnt.size(), q_cnt[0], q_cnt[1]);
        end
        vectors++;
        if (q_pix.size() !== 2 * N || lat_err !== 0 || fd_err !== 0) begin
            miscompares++;
            $display("FAIL b2b outputs got n=%0d lat=%0d fd=%0d exp n=%0d lat=0 fd=0", q_pix.size(), lat_err, fd_err, 2 * N);
        end
        repeat (5) drive(1'b0, 8'hFF, 8'h00);
        vectors++;
        if ({bus.edge_count, bus.peak_mag, bus.bbox_valid} !== {32'd1, 8'd90, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b count/peak/valid got %0d/%0d/%b exp 1/90/1", bus.edge_count, bus.peak_mag, bus.bbox_valid);
        end
        vectors++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
            miscompares++;
            $display("FAIL b2b bbox got %h exp 0001000100010001",
                     {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'd255, 8'd0);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        prev_valid   = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.edge_count, bus.bbox_valid} !== 34'd0) begin
            miscompares++;
            $display("FAIL rstmid cleared got valid=%b count=%0d bbox_valid=%b exp 0/0/0",
                     bus.out_valid, bus.edge_count, bus.bbox_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        test_ramp(1'b0, "rstmid");
    endtask

    initial begin
        test_reset();
        test_ramp(1'b0, "basic");
        test_ramp(1'b1, "gaps");
        test_zero_frame();
        test_thr_change();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/edge_threshold_stats.md
Name: edge_threshold_stats

Overview:
- Downstream consumer of the 8-bit Sobel edge-magnitude stream.
- Binarises each magnitude against a per-frame threshold and re-emits the result as a 0/255 pixel stream with frame markers.
- Accumulates per-frame statistics: edge count, peak magnitude, edge bounding box. These are published on a one-cycle frame_done pulse for the downstream writer and control logic.
- Pure streaming: no frame buffer, no backpressure (the upstream stage has none).

Parameters:
W, 630, frame width in pixels (>=2)
H, 630, frame height in pixels (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input pixel strobe, may be asserted any cycle, gaps allowed
in_pixel  in  8  edge magnitude, raster order, row-major top-to-bottom, left-to-right
thr  in  8  threshold, sampled only at first pixel of each frame
out_valid  out  1  output pixel strobe
out_pixel  out  8  binarised pixel, 8'd255 edge / 8'd0 non-edge
out_sof  out  1  qualifies first pixel of frame (x=0,y=0)
out_eol  out  1  qualifies last pixel of a row (x=W-1)
out_eof  out  1  qualifies last pixel of frame (x=W-1,y=H-1)
frame_done  out  1  one-cycle pulse, stats outputs updated this cycle
edge_count  out  32  number of edge pixels in last completed frame
peak_mag  out  8  maximum in_pixel in last completed frame
bbox_valid  out  1  1 if edge_count>0 for last completed frame
bbox_xmin  out  16  min x of edge pixels, last completed frame
bbox_xmax  out  16  max x
bbox_ymin  out  16  min y
bbox_ymax  out  16  max y

Behaviour:
- Reset (async assert, sync release): out_valid, out_sof, out_eol, out_eof, frame_done, bbox_valid = 0. out_pixel, edge_count, peak_mag, all bbox = 0. Internal x, y = 0. Accumulators cleared. Latched threshold = 0.
- Reset mid-frame discards the partial frame. The first in_valid after release is pixel (0,0).
- Position counters advance only on in_valid: x increments; at x=W-1, x wraps to 0 and y increments; at (W-1,H-1), x and y wrap to 0,0. No idle state between frames; back-to-back frames allowed with zero gap.
- Threshold latch: on an in_valid at (0,0), thr_eff = thr, and that pixel uses thr directly (not the stale latch). All other pixels use thr_eff. Changes to thr mid-frame have no effect.
- Edge decision: edge = (in_pixel >= threshold), unsigned 8-bit compare. thr=0 makes every pixel an edge; thr=255 makes only 255 an edge.
- Latency: exactly 1 cycle. out_valid(t+1) = in_valid(t). out_pixel, out_sof, out_eol, out_eof are registered with it. When out_valid=0, markers are 0 and out_pixel holds its last value.
- Accumulators (internal, per frame; the pixel at (0,0) re-initialises them rather than merging):
  - cnt += edge.
  - pk = max(pk, in_pixel).
  - If edge: xmin = min, xmax = max, ymin = min, ymax = max of the edge coordinates. The first edge of the frame initialises all four.
  - any |= edge.
- Frame completion: on the in_valid cycle at (W-1,H-1), the final accumulator values include that pixel. In the next cycle (same cycle as out_eof), frame_done=1 and edge_count, peak_mag, bbox_valid and bbox_* are loaded.
- Stats outputs hold until the next frame_done.
- If any=0: bbox_valid=0 and bbox_* = 0.
- For W=H=1-degenerate parameters, behaviour is undefined (W,H>=2 required).
- Width rules: cnt is 32-bit, no saturation needed (W*H < 2^32). Coordinates are zero-extended to 16 bits.
- States: ACTIVE only, modelled by the x/y counters. Frame boundary is implied by counter wrap.

Test Plan:
- W=4,H=3, thr=100, 12 pixels of 0..110 step 10 with no gaps -> out_pixel 0 ×10 then 255,255. edge_count=2. peak_mag=110. bbox x 2..3, y 2..2. frame_done coincides with out_eof. out_sof on 1st output, out_eol on outputs 4,8,12.
- Same frame with random in_valid gaps -> identical output sequence and stats. Each output is exactly 1 cycle after its input.
- All-zero frame, thr=1 -> all out_pixel=0, edge_count=0, bbox_valid=0, bbox=0, peak_mag=0. Then thr=0 on the next frame -> edge_count=12, bbox 0..3 × 0..2.
- thr changed from 50 to 200 mid-frame -> the whole frame uses 50. The next frame's (0,0) pixel uses the new thr value on its own cycle.
- Two back-to-back frames -> the second frame's stats exclude the first's. Stats stay stable between frame_done pulses.
- Assert rst_n low after 5 pixels, release, send a full frame -> outputs and stats reflect only the new frame, with out_sof on its first pixel.
